wb_arbiter_nm: RTL and testbench
================================

Name: wb_arbiter_nm

Overview:
- Parametrised N-master to 1-slave Wishbone classic arbiter for the user-project RAM path.
- Masters include the CPU, DMA engines and future accelerators.
- Supports fixed-priority or round-robin arbitration, bounded back-to-back bursts per grant, and a per-transaction ack timeout that returns an error.
- Sits between the master-side Wishbone ports and the single RAM slave port.

Parameters:
- NUM_M, 2: number of masters (2..8); index 0 is highest priority in fixed mode.
- DW, 32: data width, multiple of 8.
- AW, 32: address width.
- MODE, 1: 0 = fixed priority, 1 = round-robin.
- MAX_BURST, 4: max acked transfers per grant (1..255).
- TIMEOUT, 16: cycles without ack before error; 0 disables (max 255).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous reset, active-high
- m_stb_i  in  NUM_M  per-master strobe
- m_cyc_i  in  NUM_M  per-master cycle
- m_we_i  in  NUM_M  per-master write enable
- m_sel_i  in  NUM_M*DW/8  byte selects, master k at slice k
- m_dat_i  in  NUM_M*DW  write data, packed by master index
- m_adr_i  in  NUM_M*AW  addresses, packed by master index
- m_ack_o  out  NUM_M  per-master ack
- m_err_o  out  NUM_M  per-master timeout error
- m_dat_o  out  NUM_M*DW  read data, packed by master index
- s_stb_o, s_cyc_o, s_we_o  out  1 each  slave controls
- s_sel_o  out  DW/8  slave byte selects
- s_dat_o  out  DW  slave write data
- s_adr_o  out  AW  slave address
- s_ack_i  in  1  slave ack
- s_dat_i  in  DW  slave read data
- grant_o  out  NUM_M  registered one-hot owner; 0 when idle

Behaviour:
- Request: req[k] = m_stb_i[k] & m_cyc_i[k].
- States are IDLE and GRANT. Registers: owner, grant_o, burst_cnt (8b), wait_cnt (8b), rr_ptr.
- Reset: state IDLE; grant_o, burst_cnt, wait_cnt = 0; rr_ptr = NUM_M-1. All outputs are 0 during and after reset until a grant.
- IDLE, no req: remain IDLE.
- IDLE, any req: pick a winner and register it. Next cycle state = GRANT, grant_o = onehot(winner), burst_cnt = 0, wait_cnt = 0.
  - MODE 0: lowest asserted index wins.
  - MODE 1: first asserted index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_M. rr_ptr <= winner.
- Grant latency: 1 cycle from request to slave strobe. Nothing reaches the slave in IDLE.
- GRANT routing:
  - Slave outputs = owner's stb/cyc/we/sel/dat/adr, combinational.
  - m_ack_o[owner] = s_ack_i and m_dat_o[owner] = s_dat_i, same cycle.
  - Non-owners get ack = 0, err = 0, dat = 0.
  - s_ack_i outside GRANT is ignored.
- GRANT, s_ack_i = 1: burst_cnt++, wait_cnt = 0.
  - If burst_cnt+1 == MAX_BURST, go to IDLE.
  - Else stay GRANT; the owner keeps the bus while it holds cyc.
- GRANT, owner cyc = 0 (abort or burst end): go to IDLE next cycle. Slave outputs follow the owner that cycle, so s_cyc_o = 0.
- GRANT, owner cyc = 1 and stb = 0: stay GRANT; wait_cnt does not count.
- GRANT, stb & cyc & ~ack: wait_cnt++.
- Timeout: when wait_cnt == TIMEOUT-1 and still no ack (TIMEOUT != 0), pulse m_err_o[owner] for that cycle, force s_stb_o = s_cyc_o = 0 that cycle, and go to IDLE.
- Ack and timeout in the same cycle: ack wins; no err.
- Re-arbitration: the owner that leaves after MAX_BURST or timeout is not favoured. In MODE 1 rr_ptr already points at it; in MODE 0 it competes normally.
- Reset mid-transfer: immediately IDLE with all outputs 0. An in-flight slave ack is dropped.

Test Plan:
- Single request: NUM_M=2, MODE 1, m1 reads adr 0x3800_0010; slave acks 2 cycles after stb with 0xDEAD_BEEF -> grant_o = 2'b10 one cycle after req; m_ack_o = 2'b10 for one cycle with m_dat_o[1] = 0xDEAD_BEEF; m0 sees ack 0 and dat 0.
- Round-robin fairness: NUM_M=3, all masters request continuously with single transfers (cyc drops after ack) -> grant order 0, 1, 2, 0, 1, 2 starting from the reset rr_ptr = 2.
- Fixed priority: MODE 0, m0 and m2 request continuously -> only m0 is granted; m2 is granted after m0 drops cyc.
- Burst cap: MAX_BURST=4, m0 holds cyc and keeps stb with other masters requesting, slave acks every cycle -> exactly 4 acks to m0, then IDLE for one cycle, then m1 is granted.
- Timeout: TIMEOUT=16, slave never acks -> m_err_o[owner] pulses on the 16th stb cycle, s_cyc_o = 0 that cycle, next owner is granted. Second case: ack arrives on cycle 16 -> ack only, no err.
- Async reset: assert wb_rst_i mid-burst at a non-edge time -> grant_o, s_stb_o and s_cyc_o go to 0 immediately. After release, first grant follows reset rr_ptr.

Source files
------------

// File: rtl/wb_arbiter_nm.sv
// N-master to 1-slave Wishbone classic arbiter: fixed-priority or round-robin,
// bursts capped per grant, and an ack timeout that ends the cycle with an error.
module wb_arbiter_nm #(
    parameter int NUM_M     = 2,
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MODE      = 1,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*DW/8-1:0]   m_sel_i,
    input  logic [NUM_M*DW-1:0]     m_dat_i,
    input  logic [NUM_M*AW-1:0]     m_adr_i,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic [NUM_M*DW-1:0]     m_dat_o,
    output logic                    s_stb_o,
    output logic                    s_cyc_o,
    output logic                    s_we_o,
    output logic [DW/8-1:0]         s_sel_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [AW-1:0]           s_adr_o,
    input  logic                    s_ack_i,
    input  logic [DW-1:0]           s_dat_i,
    output logic [NUM_M-1:0]        grant_o
);

    localparam int SW = DW / 8;
    localparam int OW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [7:0]    BURST_LAST = 8'(MAX_BURST);
    localparam logic [7:0]    WAIT_LAST  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam logic [OW-1:0] RR_INIT    = OW'(NUM_M - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_d;
    logic [OW-1:0]     owner, owner_d;
    logic [NUM_M-1:0]  grant_d;
    logic [7:0]        burst_cnt, burst_d;
    logic [7:0]        wait_cnt, wait_d;
    logic [OW-1:0]     rr_ptr, rr_d;

    logic [NUM_M-1:0]  req;
    logic [OW-1:0]     win;
    logic              in_grant;
    logic              timeout_hit;
    logic              own_stb, own_cyc, own_we;
    logic [SW-1:0]     own_sel;
    logic [DW-1:0]     own_dat;
    logic [AW-1:0]     own_adr;

    assign req      = m_stb_i & m_cyc_i;
    assign in_grant = (state == GRANT);

    // Descending scans leave the lowest qualifying index; in round-robin the
    // indices above rr_ptr are scanned last so they override the wrapped part.
    always_comb begin
        win = '0;
        if (MODE == 0) begin
            for (int k = NUM_M - 1; k >= 0; k--)
                if (req[k]) win = OW'(k);
        end else begin
            for (int k = NUM_M - 1; k >= 0; k--)
                if (req[k] && (OW'(k) <= rr_ptr)) win = OW'(k);
            for (int k = NUM_M - 1; k >= 0; k--)
                if (req[k] && (OW'(k) > rr_ptr)) win = OW'(k);
        end
    end

    always_comb begin
        own_stb = 1'b0;
        own_cyc = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_dat = '0;
        own_adr = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (owner == OW'(k)) begin
                own_stb = m_stb_i[k];
                own_cyc = m_cyc_i[k];
                own_we  = m_we_i[k];
                own_sel = m_sel_i[k*SW +: SW];
                own_dat = m_dat_i[k*DW +: DW];
                own_adr = m_adr_i[k*AW +: AW];
            end
        end
    end

    // An ack on the last permitted wait cycle suppresses the timeout.
    assign timeout_hit = (TIMEOUT != 0) && in_grant && own_stb && own_cyc &&
                         !s_ack_i && (wait_cnt == WAIT_LAST);

    assign s_stb_o = in_grant & own_stb & ~timeout_hit;
    assign s_cyc_o = in_grant & own_cyc & ~timeout_hit;
    assign s_we_o  = in_grant & own_we;
    assign s_sel_o = in_grant ? own_sel : '0;
    assign s_dat_o = in_grant ? own_dat : '0;
    assign s_adr_o = in_grant ? own_adr : '0;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (in_grant && (owner == OW'(k))) begin
                m_ack_o[k]            = s_ack_i;
                m_err_o[k]            = timeout_hit;
                m_dat_o[k*DW +: DW]   = s_dat_i;
            end
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        grant_d = grant_o;
        burst_d = burst_cnt;
        wait_d  = wait_cnt;
        rr_d    = rr_ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    owner_d = win;
                    grant_d = NUM_M'(1) << win;
                    burst_d = 8'd0;
                    wait_d  = 8'd0;
                    if (MODE != 0) rr_d = win;
                end
            end
            GRANT: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (s_ack_i) begin
                    burst_d = burst_cnt + 8'd1;
                    wait_d  = 8'd0;
                    if ((burst_cnt + 8'd1 == BURST_LAST) || !own_cyc) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (own_stb && (wait_cnt != 8'hFF)) begin
                    wait_d = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            owner     <= '0;
            grant_o   <= '0;
            burst_cnt <= 8'd0;
            wait_cnt  <= 8'd0;
            rr_ptr    <= RR_INIT;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            grant_o   <= grant_d;
            burst_cnt <= burst_d;
            wait_cnt  <= wait_d;
            rr_ptr    <= rr_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_nm.sv
// Directed bench: a 3-master round-robin arbiter and a 3-master fixed-priority
// arbiter sharing clock and reset.
module tb_wb_arbiter_nm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // round-robin instance
    logic [2:0]  r_stb, r_cyc, r_we, r_ack, r_err, r_grant;
    logic [11:0] r_sel;
    logic [95:0] r_dat, r_adr, r_mdat;
    logic        r_s_stb, r_s_cyc, r_s_we, r_s_ack;
    logic [3:0]  r_s_sel;
    logic [31:0] r_s_dat, r_s_adr, r_s_rdat;

    // fixed-priority instance
    logic [2:0]  f_stb, f_cyc, f_we, f_ack, f_err, f_grant;
    logic [11:0] f_sel;
    logic [95:0] f_dat, f_adr, f_mdat;
    logic        f_s_stb, f_s_cyc, f_s_we, f_s_ack;
    logic [3:0]  f_s_sel;
    logic [31:0] f_s_dat, f_s_adr, f_s_rdat;

    logic [2:0]  exp_g;

    wb_arbiter_nm #(.NUM_M(3), .DW(32), .AW(32), .MODE(1), .MAX_BURST(4), .TIMEOUT(16)) u_rr (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_stb_i(r_stb), .m_cyc_i(r_cyc), .m_we_i(r_we), .m_sel_i(r_sel),
        .m_dat_i(r_dat), .m_adr_i(r_adr),
        .m_ack_o(r_ack), .m_err_o(r_err), .m_dat_o(r_mdat),
        .s_stb_o(r_s_stb), .s_cyc_o(r_s_cyc), .s_we_o(r_s_we), .s_sel_o(r_s_sel),
        .s_dat_o(r_s_dat), .s_adr_o(r_s_adr), .s_ack_i(r_s_ack), .s_dat_i(r_s_rdat),
        .grant_o(r_grant)
    );

    wb_arbiter_nm #(.NUM_M(3), .DW(32), .AW(32), .MODE(0), .MAX_BURST(4), .TIMEOUT(16)) u_fx (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_stb_i(f_stb), .m_cyc_i(f_cyc), .m_we_i(f_we), .m_sel_i(f_sel),
        .m_dat_i(f_dat), .m_adr_i(f_adr),
        .m_ack_o(f_ack), .m_err_o(f_err), .m_dat_o(f_mdat),
        .s_stb_o(f_s_stb), .s_cyc_o(f_s_cyc), .s_we_o(f_s_we), .s_sel_o(f_s_sel),
        .s_dat_o(f_s_dat), .s_adr_o(f_s_adr), .s_ack_i(f_s_ack), .s_dat_i(f_s_rdat),
        .grant_o(f_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        r_stb = '0; r_cyc = '0; r_we = '0; r_sel = '0; r_dat = '0; r_adr = '0;
        r_s_ack = 1'b0; r_s_rdat = '0;
        f_stb = '0; f_cyc = '0; f_we = '0; f_sel = '0; f_dat = '0; f_adr = '0;
        f_s_ack = 1'b0; f_s_rdat = '0;

        // reset state
        #3;
        chk("rst_grant", 32'(r_grant), 32'd0);
        chk("rst_s_stb", 32'(r_s_stb), 32'd0);
        chk("rst_s_cyc", 32'(r_s_cyc), 32'd0);
        chk("rst_ack", 32'(r_ack), 32'd0);
        #9 rst = 1'b0;
        step();

        // round-robin fairness from reset pointer 2: order 0,1,2,0,1,2
        r_stb = 3'b111; r_cyc = 3'b111;
        for (int i = 0; i < 6; i++) begin
            exp_g = 3'b001 << (i % 3);
            #1;
            chk("rr_idle_grant", 32'(r_grant), 32'd0);
            step();
            r_s_ack = 1'b1;
            #1;
            chk("rr_grant", 32'(r_grant), 32'(exp_g));
            chk("rr_ack", 32'(r_ack), 32'(exp_g));
            step();
            r_s_ack = 1'b0;
            r_stb = r_stb & ~exp_g;
            r_cyc = r_cyc & ~exp_g;
            #1;
            chk("rr_cyc_drop", 32'(r_s_cyc), 32'd0);
            step();
            r_stb = 3'b111; r_cyc = 3'b111;
        end

        // single read by m1, slave acks two cycles after the strobe
        r_stb = 3'b010; r_cyc = 3'b010; r_we = 3'b000;
        r_adr = {32'h2222_0000, 32'h3800_0010, 32'h1111_0000};
        #1;
        chk("single_latency", 32'(r_s_stb), 32'd0);
        step();
        #1;
        chk("single_grant", 32'(r_grant), 32'h2);
        chk("single_s_stb", 32'(r_s_stb), 32'd1);
        chk("single_s_adr", r_s_adr, 32'h3800_0010);
        step();
        #1;
        chk("single_wait_ack", 32'(r_ack), 32'd0);
        step();
        r_s_ack = 1'b1; r_s_rdat = 32'hDEAD_BEEF;
        #1;
        chk("single_ack", 32'(r_ack), 32'h2);
        chk("single_dat_m1", r_mdat[63:32], 32'hDEAD_BEEF);
        chk("single_dat_m0", r_mdat[31:0], 32'd0);
        chk("single_err", 32'(r_err), 32'd0);
        step();
        r_s_ack = 1'b0; r_stb = '0; r_cyc = '0;
        #1;
        chk("single_cyc_end", 32'(r_s_cyc), 32'd0);
        step();
        #1;
        chk("single_idle", 32'(r_grant), 32'd0);

        // burst cap: m0 alone wins, then everyone requests; four acks then IDLE
        r_stb = 3'b001; r_cyc = 3'b001;
        step();
        r_stb = 3'b111; r_cyc = 3'b111; r_s_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("burst_grant", 32'(r_grant), 32'h1);
            chk("burst_ack", 32'(r_ack), 32'h1);
            step();
        end
        #1;
        chk("burst_idle_grant", 32'(r_grant), 32'd0);
        chk("burst_idle_ack", 32'(r_ack), 32'd0);
        chk("burst_idle_stb", 32'(r_s_stb), 32'd0);
        r_s_ack = 1'b0;
        step();

        // timeout: m1 owns, slave silent; error on the 16th strobe cycle
        for (int i = 1; i <= 16; i++) begin
            #1;
            chk("to_grant", 32'(r_grant), 32'h2);
            if (i < 16) begin
                chk("to_no_err", 32'(r_err), 32'd0);
                chk("to_s_stb", 32'(r_s_stb), 32'd1);
            end else begin
                chk("to_err", 32'(r_err), 32'h2);
                chk("to_s_cyc", 32'(r_s_cyc), 32'd0);
                chk("to_s_stb_off", 32'(r_s_stb), 32'd0);
            end
            step();
        end
        #1;
        chk("to_idle", 32'(r_grant), 32'd0);
        step();

        // ack on the 16th cycle beats the timeout; m2 is next after m1
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) r_s_ack = 1'b1;
            #1;
            chk("to2_grant", 32'(r_grant), 32'h4);
            if (i == 16) begin
                chk("to2_ack", 32'(r_ack), 32'h4);
                chk("to2_no_err", 32'(r_err), 32'd0);
                chk("to2_s_cyc", 32'(r_s_cyc), 32'd1);
            end
            step();
        end

        // asynchronous reset in mid-burst with an ack in flight
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", 32'(r_grant), 32'd0);
        chk("arst_s_stb", 32'(r_s_stb), 32'd0);
        chk("arst_s_cyc", 32'(r_s_cyc), 32'd0);
        chk("arst_ack", 32'(r_ack), 32'd0);
        #9 rst = 1'b0; r_s_ack = 1'b0;
        step();
        #1;
        chk("arst_first_grant", 32'(r_grant), 32'h1);
        r_stb = '0; r_cyc = '0;
        step();
        step();

        // fixed priority: m0 beats m2 until m0 drops cyc
        f_stb = 3'b101; f_cyc = 3'b101;
        step();
        f_s_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fx_grant", 32'(f_grant), 32'h1);
            chk("fx_ack", 32'(f_ack), 32'h1);
            step();
        end
        #1;
        chk("fx_idle", 32'(f_grant), 32'd0);
        f_s_ack = 1'b0;
        step();
        #1;
        chk("fx_regrant_m0", 32'(f_grant), 32'h1);
        f_stb = 3'b100; f_cyc = 3'b100;
        #1;
        chk("fx_drop_cyc", 32'(f_s_cyc), 32'd0);
        step();
        #1;
        chk("fx_idle2", 32'(f_grant), 32'd0);
        step();
        #1;
        chk("fx_grant_m2", 32'(f_grant), 32'h4);
        f_stb = '0; f_cyc = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
